axis_1553_rt_rx_sequencer: RTL
==============================

Name: axis_1553_rt_rx_sequencer

Overview:
- Sits directly downstream of the 1553 Manchester decoder's AXIS word output, inside an RT receive path.
- Validates command words against the local RT address and decodes the expected data-word count.
- Collects the data words and forwards each complete message as a framed AXIS packet.
- Detects parity, framing and inter-word gap errors. Terminates every message with a tlast beat and publishes status pulses and counters for the APB register block.

Parameters:
- clock_speed, 20000000, aclk frequency in Hz.
- gap_timeout_us, 24, maximum µs between accepted words inside a message before abort. gap_cycles = (clock_speed/1000000)*gap_timeout_us.

Ports:
- aclk  in  1  clock
- arstn  in  1  synchronous active-low reset
- s_axis_tdata  in  16  decoded word
- s_axis_tuser  in  8  [7:5] sync type: 100 = command/status, 010 = data; [2] pre-gap flag; [1] invert flag; [0] parity good (1 = good)
- s_axis_tvalid  in  1  word valid
- s_axis_tready  out  1  word accept
- rt_address  in  5  local RT address
- broadcast_en  in  1  accept address 31 commands
- m_axis_tdata  out  16  message word
- m_axis_tuser  out  2  [0] = command word, [1] = error terminator
- m_axis_tlast  out  1  last beat of message
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- msg_done  out  1  one-cycle pulse, good message complete
- msg_error  out  1  one-cycle pulse, message aborted
- err_code  out  2  last error: 1 = parity, 2 = unexpected command sync, 3 = gap timeout; held until next error
- msg_count  out  16  good messages, saturating
- err_count  out  16  aborted messages, saturating

Behaviour:
- Reset values (arstn = 0 at posedge aclk): state = IDLE; every output, counter and holding register = 0; s_axis_tready = 0 during reset. Reset mid-message discards it; no terminator is emitted.
- Handshakes:
  - Transfers occur on valid & ready.
  - Output is a 1-deep holding register. s_axis_tready = (state ∈ {IDLE, RX_DATA}) & (!m_axis_tvalid | m_axis_tready).
  - Latency: an accepted word appears on m_axis the next cycle.
  - m_axis_tvalid stays high, with data stable, until m_axis_tready is high.
- Command decode: [15:11] RT address, [10] T/R, [9:5] subaddress, [4:0] word count/mode code.
  - Normal subaddress: expected = (T/R = 1) ? 0 : (wc == 0 ? 32 : wc).
  - Mode command (subaddress 0 or 31): expected = (T/R = 0 & code[4] = 1) ? 1 : 0.
- State IDLE:
  - Word with sync ≠ 100, or parity bad, or address ≠ rt_address (and not 31 with broadcast_en = 1): consume and drop, no status.
  - Matching good command: forward it with tuser = 01; load remaining = expected; clear gap timer.
  - expected = 0: tlast = 1 on the command beat, go to DONE.
  - Otherwise go to RX_DATA.
- State RX_DATA:
  - Gap timer increments each cycle; it is frozen while m_axis_tvalid & !m_axis_tready.
  - Each accepted word clears the timer.
  - Parity bad → ERROR, err_code = 1.
  - Sync = 100 → ERROR, err_code = 2; that command is discarded, not reprocessed.
  - Otherwise forward with tuser = 00 and decrement remaining; tlast = 1 when remaining reaches 0, then go to DONE.
  - Timer == gap_cycles-1 with no word accepted → ERROR, err_code = 3.
  - A word accepted in the same cycle the timer expires takes priority: it is processed and the timer is cleared.
- State DONE: one cycle; pulse msg_done, increment msg_count (saturating at 0xFFFF), go to IDLE.
- State ERROR:
  - Wait until the holding register is free (!m_axis_tvalid | m_axis_tready).
  - Load the terminator: tdata = 0, tuser = 10, tlast = 1.
  - Pulse msg_error, increment err_count (saturating), go to IDLE.
  - The error word itself is never forwarded.
- Counters: msg_count and err_count hold at 0xFFFF; no wrap.
- Pre-gap and invert flags (tuser[2:1]) are ignored by this block.

Test Plan:
- rt_address = 5; command 0x2822 (RT 5, receive, SA 1, wc 2), then data 0x1111 and 0x2222, all parity good, m_axis_tready = 1 → three beats, tuser 01/00/00, tlast on 0x2222; msg_done pulses once; msg_count = 1.
- Transmit command 0x2C20 (RT 5, T/R = 1) → single beat, tuser = 01, tlast = 1; msg_done pulses. Command to RT 6 (0x3022) → nothing forwarded, counters unchanged. RT 31 command with broadcast_en = 0 → dropped; with broadcast_en = 1 → accepted.
- wc = 0 command 0x2820 followed by 32 data words → 33 beats, tlast on the 32nd data word.
- After a wc = 2 command, send one data word, then stall 480 cycles (gap_cycles at defaults) → terminator beat tdata = 0, tuser = 10, tlast = 1; err_code = 3; err_count = 1.
- Data word with tuser[0] = 0 mid-message → err_code = 1 terminator. Command-sync word mid-message → err_code = 2; the following data words are dropped in IDLE.
- Hold m_axis_tready = 0 for 100 cycles mid-message → s_axis_tready = 0, no word lost, gap timer frozen (no timeout); after release all beats emerge in order. Assert arstn = 0 mid-message → all outputs 0 next cycle, no terminator emitted.

Source files
------------

// File: rtl/axis_1553_rt_rx_sequencer_if.sv
// AXI-Stream style word bus used on both sides of the 1553 RT receive sequencer.
// No latency of its own; it only bundles wires.
// Backpressure is the usual tvalid/tready pair: a beat moves only when both are high.
interface axis_1553_rt_rx_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int USER_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (
        output tdata,
        output tuser,
        output tlast,
        output tvalid,
        input  tready
    );

    // The decoder side carries no framing, so tlast is not part of the sink view.
    modport slave (
        input  tdata,
        input  tuser,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_1553_rt_rx_sequencer.sv
// Validates 1553 command words for this RT, collects their data words and frames each message on m_axis.
// Latency: an accepted word appears on m_axis the next cycle; aborts append a tdata=0/tuser=10 terminator.
// Backpressure: 1-deep output register; s_axis_tready drops while it is full and not being drained.
module axis_1553_rt_rx_sequencer #(
    parameter int clock_speed    = 20000000,
    parameter int gap_timeout_us = 24
) (
    input  logic                                 aclk,
    input  logic                                 arstn,
    axis_1553_rt_rx_sequencer_if.slave           s_axis,
    axis_1553_rt_rx_sequencer_if.master          m_axis,
    input  logic [4:0]                           rt_address,
    input  logic                                 broadcast_en,
    output logic                                 msg_done,
    output logic                                 msg_error,
    output logic [1:0]                           err_code,
    output logic [15:0]                          msg_count,
    output logic [15:0]                          err_count
);

    localparam int GAP_CYCLES = (clock_speed / 1000000) * gap_timeout_us;
    localparam int GAP_W      = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RX_DATA = 2'd1,
        DONE    = 2'd2,
        ERROR   = 2'd3
    } state_t;

    state_t           state;
    logic [5:0]       remaining;
    logic [GAP_W-1:0] gap_timer;

    logic [15:0]      m_data_q;
    logic [1:0]       m_user_q;
    logic             m_last_q;
    logic             m_vld_q;

    // Field split of the incoming word
    logic [2:0] sync;
    logic       parity_ok;
    logic       is_cmd;
    logic [4:0] cmd_addr;
    logic       cmd_tr;
    logic [4:0] cmd_sa;
    logic [4:0] cmd_wc;
    logic       addr_hit;
    logic [5:0] cmd_words;
    logic       s_rdy;
    logic       s_fire;
    logic       out_free;
    logic       stalled;

    // Pre-gap and invert flags carry nothing this block acts on.
    logic       unused_flags;

    assign sync      = s_axis.tuser[7:5];
    assign parity_ok = s_axis.tuser[0];
    assign is_cmd    = (sync == 3'b100);
    assign cmd_addr  = s_axis.tdata[15:11];
    assign cmd_tr    = s_axis.tdata[10];
    assign cmd_sa    = s_axis.tdata[9:5];
    assign cmd_wc    = s_axis.tdata[4:0];
    assign addr_hit  = (cmd_addr == rt_address) || ((cmd_addr == 5'd31) && broadcast_en);
    assign unused_flags = ^s_axis.tuser[4:1];

    assign out_free = !m_vld_q || m_axis.tready;
    assign stalled  = m_vld_q && !m_axis.tready;
    assign s_rdy    = arstn && ((state == IDLE) || (state == RX_DATA)) && out_free;
    assign s_fire   = s_axis.tvalid && s_rdy;

    assign s_axis.tready = s_rdy;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tuser  = m_user_q;
    assign m_axis.tlast  = m_last_q;
    assign m_axis.tvalid = m_vld_q;

    // Number of data words the command promises: mode codes carry at most one, transmits carry none.
    always_comb begin
        cmd_words = 6'd0;
        if ((cmd_sa == 5'd0) || (cmd_sa == 5'd31)) begin
            cmd_words = (!cmd_tr && cmd_wc[4]) ? 6'd1 : 6'd0;
        end else if (!cmd_tr) begin
            cmd_words = (cmd_wc == 5'd0) ? 6'd32 : {1'b0, cmd_wc};
        end
    end

    // Message sequencer: owns the output holding register, gap timer, status pulses and counters.
    always_ff @(posedge aclk) begin
        if (!arstn) begin
            state     <= IDLE;
            remaining <= '0;
            gap_timer <= '0;
            m_data_q  <= '0;
            m_user_q  <= '0;
            m_last_q  <= 1'b0;
            m_vld_q   <= 1'b0;
            msg_done  <= 1'b0;
            msg_error <= 1'b0;
            err_code  <= '0;
            msg_count <= '0;
            err_count <= '0;
        end else begin
            msg_done  <= 1'b0;
            msg_error <= 1'b0;
            if (m_vld_q && m_axis.tready) begin
                m_vld_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // Anything that is not a clean command for us is swallowed silently.
                    if (s_fire && is_cmd && parity_ok && addr_hit) begin
                        m_data_q  <= s_axis.tdata;
                        m_user_q  <= 2'b01;
                        m_vld_q   <= 1'b1;
                        remaining <= cmd_words;
                        gap_timer <= '0;
                        if (cmd_words == 6'd0) begin
                            m_last_q <= 1'b1;
                            state    <= DONE;
                        end else begin
                            m_last_q <= 1'b0;
                            state    <= RX_DATA;
                        end
                    end
                end

                RX_DATA: begin
                    // An arriving word wins over a timer expiring in the same cycle.
                    if (s_fire) begin
                        gap_timer <= '0;
                        if (!parity_ok) begin
                            err_code <= 2'd1;
                            state    <= ERROR;
                        end else if (is_cmd) begin
                            err_code <= 2'd2;
                            state    <= ERROR;
                        end else begin
                            m_data_q  <= s_axis.tdata;
                            m_user_q  <= 2'b00;
                            m_vld_q   <= 1'b1;
                            m_last_q  <= (remaining == 6'd1);
                            remaining <= remaining - 6'd1;
                            if (remaining == 6'd1) begin
                                state <= DONE;
                            end
                        end
                    end else if (!stalled) begin
                        // Time spent waiting on the downstream sink is not charged to the bus.
                        if (gap_timer == GAP_LAST) begin
                            err_code <= 2'd3;
                            state    <= ERROR;
                        end else begin
                            gap_timer <= gap_timer + GAP_W'(1);
                        end
                    end
                end

                DONE: begin
                    msg_done <= 1'b1;
                    if (msg_count != 16'hFFFF) begin
                        msg_count <= msg_count + 16'd1;
                    end
                    state <= IDLE;
                end

                ERROR: begin
                    if (out_free) begin
                        m_data_q  <= 16'h0000;
                        m_user_q  <= 2'b10;
                        m_last_q  <= 1'b1;
                        m_vld_q   <= 1'b1;
                        msg_error <= 1'b1;
                        if (err_count != 16'hFFFF) begin
                            err_count <= err_count + 16'd1;
                        end
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
